// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampled UART receiver with break/parity/frame detection
// feeding a receive FIFO with RTS flow control.
module uart_rx_fifo #(
    parameter int SYSCLK_RATE   = 100000000,
    parameter int BAUD_RATE     = 9600,
    parameter int OVERSAMPLE    = 16,
    parameter int DATA_BITS     = 8,
    parameter int PARITY_MODE   = 1,
    parameter int STOP_BITS     = 2,
    parameter int MSB_FIRST     = 1,
    parameter int FIFO_WIDTH    = 4,
    parameter int RTS_THRESHOLD = 2**FIFO_WIDTH - 2
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Rx,
    input  logic                 Pop_Data,
    output logic [DATA_BITS-1:0] Data_Out,
    output logic [2:0]           Rx_Error,
    output logic                 Data_Rdy,
    output logic                 FIFO_Empty,
    output logic                 FIFO_Full,
    output logic                 FIFO_Overflow,
    output logic                 RTS,
    output logic                 Rx_Busy
);
    localparam int DIV     = SYSCLK_RATE / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PH_W    = $clog2(OVERSAMPLE);
    localparam int BC_W    = 4;
    localparam int DEPTH   = 2**FIFO_WIDTH;
    localparam int CNT_W   = FIFO_WIDTH + 1;
    localparam int ENTRY_W = DATA_BITS + 3;
    localparam logic PAR_ODD = (PARITY_MODE == 2);

    if (DIV < 1 || OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0 ||
        DATA_BITS < 5 || DATA_BITS > 9) begin : g_param_check
        $error("uart_rx_fifo: illegal parameter combination");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_t;

    logic                  rx_meta, rx_sync, rx_prev, falling;
    logic [DIV_W-1:0]      div_cnt;
    logic                  tick;
    state_t                state, state_nxt;
    logic [PH_W-1:0]       phase;
    logic [BC_W-1:0]       bit_cnt;
    logic [DATA_BITS-1:0]  shift;
    logic                  par_err, frm_err, all_zero;
    logic                  smp_half, smp_full, last_data, last_stop, brk_now;
    logic                  vld_p0;
    logic [ENTRY_W-1:0]    entry_p0;
    logic [ENTRY_W-1:0]    mem [DEPTH];
    logic [FIFO_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  full, do_push, do_pop;

    // Stage: line synchroniser and edge detect
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= Rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign falling = rx_prev & ~rx_sync;
    assign tick    = (div_cnt == DIV_W'(DIV - 1));

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) div_cnt <= '0;
        else     div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
    end

    assign smp_half  = tick && (phase == PH_W'(OVERSAMPLE / 2 - 1));
    assign smp_full  = tick && (phase == PH_W'(OVERSAMPLE - 1));
    assign last_data = (bit_cnt == BC_W'(DATA_BITS - 1));
    assign last_stop = (bit_cnt == BC_W'(STOP_BITS - 1));
    assign brk_now   = all_zero & ~rx_sync;

    // Stage: frame decoder
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (falling) state_nxt = START;
            START:    if (smp_half) state_nxt = rx_sync ? IDLE : DATA;
            DATA:     if (smp_full && last_data) state_nxt = (PARITY_MODE == 0) ? STOP : PARITY;
            PARITY:   if (smp_full) state_nxt = STOP;
            STOP:     if (smp_full && last_stop) state_nxt = brk_now ? BRK_WAIT : IDLE;
            BRK_WAIT: if (rx_sync) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // The phase realigns to the start edge, then to mid-bit after the start sample
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            phase   <= '0;
            bit_cnt <= '0;
            vld_p0  <= 1'b0;
        end else begin
            if (state == IDLE && falling)
                phase <= '0;
            else if (tick)
                phase <= (smp_full || (state == START && smp_half)) ? '0 : phase + PH_W'(1);
            bit_cnt <= (state_nxt != state) ? '0 : bit_cnt + BC_W'(smp_full);
            vld_p0  <= (state == STOP) && smp_full && last_stop;
        end
    end

    always_ff @(posedge Clk) begin
        if (state == START && smp_half) begin
            par_err  <= 1'b0;
            frm_err  <= 1'b0;
            all_zero <= 1'b1;
        end else if (smp_full && (state == DATA || state == PARITY || state == STOP)) begin
            all_zero <= all_zero & ~rx_sync;
            if (state == DATA) begin
                if (MSB_FIRST != 0) shift <= {shift[DATA_BITS-2:0], rx_sync};
                else                shift <= {rx_sync, shift[DATA_BITS-1:1]};
            end
            if (state == PARITY) par_err <= rx_sync ^ (^shift) ^ PAR_ODD;
            if (state == STOP) begin
                frm_err <= frm_err | ~rx_sync;
                if (last_stop)
                    entry_p0 <= brk_now ? {3'b101, {DATA_BITS{1'b0}}}
                                        : {frm_err | ~rx_sync, par_err, 1'b0, shift};
            end
        end
    end

    // Stage: receive FIFO
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = Pop_Data && (count != '0);
    assign do_push = vld_p0 && (!full || do_pop);

    always_ff @(posedge Clk) begin
        if (do_push) mem[wr_ptr] <= entry_p0;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            FIFO_Overflow <= 1'b0;
            RTS           <= 1'b1;
            Data_Out      <= '0;
            Rx_Error      <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + FIFO_WIDTH'(1);
            if (do_pop) begin
                rd_ptr                <= rd_ptr + FIFO_WIDTH'(1);
                {Rx_Error, Data_Out}  <= mem[rd_ptr];
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
            if (vld_p0 && !do_push) FIFO_Overflow <= 1'b1;
            RTS <= (count < CNT_W'(RTS_THRESHOLD));
        end
    end

    assign FIFO_Empty = (count == '0);
    assign FIFO_Full  = full;
    assign Data_Rdy   = ~FIFO_Empty;
    assign Rx_Busy    = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed and randomized bench for uart_rx_fifo, checked against a
// frame-level reference model with a 4-entry queue.
module tb_uart_rx_fifo;
    localparam int BIT_T  = 16;
    localparam int DEPTH  = 4;
    localparam int RTS_TH = 3;

    logic       Clk = 1'b0;
    logic       Rst, Rx, Pop_Data;
    logic [7:0] Data_Out;
    logic [2:0] Rx_Error;
    logic       Data_Rdy, FIFO_Empty, FIFO_Full, FIFO_Overflow, RTS, Rx_Busy;

    uart_rx_fifo #(
        .SYSCLK_RATE(1600), .BAUD_RATE(100), .OVERSAMPLE(16), .DATA_BITS(8),
        .PARITY_MODE(1), .STOP_BITS(2), .MSB_FIRST(1), .FIFO_WIDTH(2),
        .RTS_THRESHOLD(3)
    ) dut (
        .Clk(Clk), .Rst(Rst), .Rx(Rx), .Pop_Data(Pop_Data),
        .Data_Out(Data_Out), .Rx_Error(Rx_Error), .Data_Rdy(Data_Rdy),
        .FIFO_Empty(FIFO_Empty), .FIFO_Full(FIFO_Full),
        .FIFO_Overflow(FIFO_Overflow), .RTS(RTS), .Rx_Busy(Rx_Busy)
    );

    always #5 Clk = ~Clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [10:0] mq[$];
    logic        m_ovf;
    logic [7:0]  m_data;
    logic [2:0]  m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf  = 1'b0;
        m_data = 8'h00;
        m_err  = 3'b000;
    endtask

    // Line order: [0] start, [8:1] data MSB first, [9] parity, [11:10] stops
    function automatic logic [11:0] make_frame(input logic [7:0] d, input logic pf,
                                               input logic [1:0] st);
        logic [11:0] fr;
        fr[0] = 1'b0;
        for (int i = 0; i < 8; i++) fr[1+i] = d[7-i];
        fr[9]     = (^d) ^ pf;
        fr[11:10] = st;
        return fr;
    endfunction

    task automatic model_frame(input logic [11:0] fr);
        logic [7:0] d;
        logic [2:0] e;
        if (fr == 12'h000) begin
            d = 8'h00;
            e = 3'b101;
        end else begin
            for (int i = 0; i < 8; i++) d[7-i] = fr[1+i];
            e[0] = 1'b0;
            e[1] = (fr[9] != (^d));
            e[2] = !(fr[10] && fr[11]);
        end
        if (mq.size() < DEPTH) mq.push_back({e, d});
        else                   m_ovf = 1'b1;
    endtask

    task automatic send_frame(input logic [11:0] fr);
        for (int i = 0; i < 12; i++) begin
            Rx = fr[i];
            repeat (BIT_T) @(negedge Clk);
        end
        Rx = 1'b1;
        repeat (6) @(negedge Clk);
        model_frame(fr);
    endtask

    task automatic check_status(input string tag);
        repeat (2) @(negedge Clk);
        check({tag, ".empty"}, 32'(FIFO_Empty),    32'(mq.size() == 0));
        check({tag, ".full"},  32'(FIFO_Full),     32'(mq.size() == DEPTH));
        check({tag, ".rdy"},   32'(Data_Rdy),      32'(mq.size() != 0));
        check({tag, ".ovf"},   32'(FIFO_Overflow), 32'(m_ovf));
        check({tag, ".rts"},   32'(RTS),           32'(mq.size() < RTS_TH));
        check({tag, ".busy"},  32'(Rx_Busy),       32'd0);
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".data"}, 32'(Data_Out), 32'(m_data));
        check({tag, ".err"},  32'(Rx_Error), 32'(m_err));
        check_status(tag);
    endtask

    task automatic pop(input string tag);
        Pop_Data = 1'b1;
        @(negedge Clk);
        Pop_Data = 1'b0;
        if (mq.size() > 0) {m_err, m_data} = mq.pop_front();
        check_regs(tag);
    endtask

    initial begin
        Rst = 1'b1;
        Rx = 1'b1;
        Pop_Data = 1'b0;
        model_reset();
        repeat (3) @(negedge Clk);
        check_regs("rst_hold");
        Rst = 1'b0;
        check_regs("rst_rel");

        send_frame(make_frame(8'hA5, 1'b0, 2'b11));
        check_status("a5");
        pop("a5");
        check("a5.lit", 32'(Data_Out), 32'h0A5);
        check("a5.lit_err", 32'(Rx_Error), 32'd0);

        send_frame(make_frame(8'hAA, 1'b1, 2'b11));
        pop("par");
        check("par.lit_err", 32'(Rx_Error), 32'b010);

        send_frame(make_frame(8'hAA, 1'b0, 2'b00));
        pop("frm");
        check("frm.lit_err", 32'(Rx_Error), 32'b100);

        Rx = 1'b0;
        repeat (19 * BIT_T) @(negedge Clk);
        check("brk.busy_low", 32'(Rx_Busy), 32'd1);
        repeat (BIT_T) @(negedge Clk);
        Rx = 1'b1;
        repeat (6) @(negedge Clk);
        model_frame(12'h000);
        check_status("brk");
        pop("brk");
        check("brk.lit", {21'd0, Rx_Error, Data_Out}, {21'd0, 3'b101, 8'h00});

        Rx = 1'b0;
        repeat (2) @(negedge Clk);
        check("glitch.lat2", 32'(Rx_Busy), 32'd0);
        @(negedge Clk);
        check("glitch.lat3", 32'(Rx_Busy), 32'd1);
        @(negedge Clk);
        Rx = 1'b1;
        repeat (10) @(negedge Clk);
        check("glitch.idle", 32'(Rx_Busy), 32'd0);
        check_status("glitch");

        for (int v = 0; v < 5; v++) begin
            send_frame(make_frame(8'(v), 1'b0, 2'b11));
            check_status("fill");
        end
        check("fill.ovf_lit", 32'(FIFO_Overflow), 32'd1);
        for (int k = 0; k < 4; k++) begin
            pop("drain");
            check("drain.lit", 32'(Data_Out), 32'(k));
        end
        pop("drain_empty");

        for (int n = 0; n < 16; n++) begin
            logic [7:0] d;
            logic       pf;
            logic [1:0] st;
            int         kind;
            d    = 8'($urandom);
            kind = int'($urandom_range(0, 5));
            pf   = 1'b0;
            st   = 2'b11;
            if (kind == 0) pf = 1'b1;
            else if (kind == 1) st = 2'($urandom_range(0, 2));
            else if (kind == 2) begin
                d  = 8'h00;
                st = 2'b00;
            end
            send_frame(make_frame(d, pf, st));
            check_status("rnd");
            if ($urandom_range(0, 2) != 0) pop("rnd_pop");
        end

        send_frame(make_frame(8'h5A, 1'b0, 2'b11));
        pop("pre_rst");
        begin
            logic [11:0] fr;
            fr = make_frame(8'h77, 1'b0, 2'b11);
            for (int i = 0; i < 6; i++) begin
                Rx = fr[i];
                repeat (BIT_T) @(negedge Clk);
            end
        end
        Rst = 1'b1;
        Rx  = 1'b1;
        model_reset();
        repeat (3) @(negedge Clk);
        check("midrst.busy", 32'(Rx_Busy), 32'd0);
        Rst = 1'b0;
        repeat (40) @(negedge Clk);
        check_regs("midrst");
        pop("midrst_empty");

        send_frame(make_frame(8'hC3, 1'b0, 2'b11));
        pop("recover");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
